// File: rtl/iq_discriminator_if.sv
// ----------------------------------------------------------------------------
// iq_discriminator_if
// Bundles the control, sample and result signals of the IQ state
// discriminator into one interface.
//
// Signals:
//   start          one-cycle pulse that begins a shot batch
//   num_shots      shots per batch, captured with start
//   w_i, w_q       signed projection weights, captured with start
//   threshold      signed 48-bit decision threshold, captured with start
//   iq_valid       one-cycle strobe marking a valid i_val/q_val pair
//   i_val, q_val   signed 32-bit integrated I and Q values
//   state_valid    one-cycle strobe marking a valid state_bit
//   state_bit      shot classification, 1 = excited
//   busy           batch in progress (RUN or DONE)
//   done           one-cycle batch-complete pulse
//   shot_count     shots classified in the current/last batch
//   excited_count  excited shots in the current/last batch
//
// Modports:
//   master  drives the controls and samples, observes the results
//   slave   the discriminator itself
// ----------------------------------------------------------------------------
interface iq_discriminator_if #(
   parameter int COEF_W = 16,
   parameter int CNT_W  = 16
);

   logic                     start;
   logic [CNT_W-1:0]         num_shots;
   logic signed [COEF_W-1:0] w_i;
   logic signed [COEF_W-1:0] w_q;
   logic signed [47:0]       threshold;
   logic                     iq_valid;
   logic signed [31:0]       i_val;
   logic signed [31:0]       q_val;
   logic                     state_valid;
   logic                     state_bit;
   logic                     busy;
   logic                     done;
   logic [CNT_W-1:0]         shot_count;
   logic [CNT_W-1:0]         excited_count;

   modport master (
      output start, num_shots, w_i, w_q, threshold,
      output iq_valid, i_val, q_val,
      input  state_valid, state_bit, busy, done,
      input  shot_count, excited_count
   );

   modport slave (
      input  start, num_shots, w_i, w_q, threshold,
      input  iq_valid, i_val, q_val,
      output state_valid, state_bit, busy, done,
      output shot_count, excited_count
   );

endinterface

// File: rtl/iq_discriminator.sv
// ----------------------------------------------------------------------------
// iq_discriminator
// Classifies integrated readout samples as ground or excited. Each sample
// is projected onto a weight vector (proj = i_val*w_i + q_val*w_q) and
// compared against a threshold. A batch of num_shots classifications is
// run per start pulse, with running totals of shots and excited shots.
//
// Pipeline: edge 1 registers the two products, edge 2 registers the sum
// comparison, so state_valid follows an accepted iq_valid by two cycles and
// back-to-back samples produce back-to-back results.
//
// Ports:
//   clk100  system clock, all logic on the rising edge
//   reset   synchronous, active-high reset
//   bus     iq_discriminator_if slave modport (controls, samples, results)
// ----------------------------------------------------------------------------
module iq_discriminator #(
   parameter int COEF_W = 16,
   parameter int CNT_W  = 16
) (
   input logic                clk100,
   input logic                reset,
   iq_discriminator_if.slave  bus
);

   // Product width is the exact width of a 32-bit by COEF_W-bit signed
   // multiply; the comparison width is one bit wider so that adding two
   // extreme products cannot wrap, and never narrower than the threshold.
   localparam int PROD_W = 32 + COEF_W;
   localparam int SUM_W  = PROD_W + 1;
   localparam int CMP_W  = (SUM_W > 49) ? SUM_W : 49;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   // Batch configuration captured on an accepted start
   logic [CNT_W-1:0]         num_lat;
   logic signed [COEF_W-1:0] wi_lat;
   logic signed [COEF_W-1:0] wq_lat;
   logic signed [47:0]       th_lat;

   // Number of samples taken into the pipeline in this batch
   logic [CNT_W-1:0]         accept_count;

   // Stage 1 registers
   logic signed [PROD_W-1:0] p_i;
   logic signed [PROD_W-1:0] p_q;
   logic                     v1;

   // Registered outputs
   logic                     state_valid_r;
   logic                     state_bit_r;
   logic                     busy_r;
   logic                     done_r;
   logic [CNT_W-1:0]         shot_count_r;
   logic [CNT_W-1:0]         excited_count_r;

   // Combinational helpers
   logic                     start_accept;
   logic                     sample_accept;
   logic                     last_shot;
   logic                     busy_next;
   logic                     done_next;
   logic signed [CMP_W-1:0]  proj;
   logic signed [CMP_W-1:0]  th_ext;
   logic                     excited;

   // Operands widened to the product width before multiplying so the
   // multiply is a full-precision signed product.
   logic signed [PROD_W-1:0] i_ext;
   logic signed [PROD_W-1:0] q_ext;
   logic signed [PROD_W-1:0] wi_ext;
   logic signed [PROD_W-1:0] wq_ext;

   assign i_ext  = $signed({{COEF_W{bus.i_val[31]}}, bus.i_val});
   assign q_ext  = $signed({{COEF_W{bus.q_val[31]}}, bus.q_val});
   assign wi_ext = $signed({{32{wi_lat[COEF_W-1]}}, wi_lat});
   assign wq_ext = $signed({{32{wq_lat[COEF_W-1]}}, wq_lat});

   // Sum and threshold are both sign-extended to the comparison width so
   // the decision is a true signed compare with no overflow.
   assign proj = $signed({{(CMP_W-PROD_W){p_i[PROD_W-1]}}, p_i})
               + $signed({{(CMP_W-PROD_W){p_q[PROD_W-1]}}, p_q});
   assign th_ext  = $signed({{(CMP_W-48){th_lat[47]}}, th_lat});
   assign excited = (proj > th_ext);

   // State register; busy and done are registered alongside the state so
   // they line up exactly with the state they describe.
   always_ff @(posedge clk100) begin
      if (reset) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         state  <= next_state;
         busy_r <= busy_next;
         done_r <= done_next;
      end
   end

   // Next-state logic. The batch ends on the edge where the final shot
   // leaves stage 2, i.e. when shot_count is about to reach num_shots.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               next_state = (bus.num_shots == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_shot) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output and acceptance decode. Samples are refused once the batch has
   // taken num_shots of them, even while earlier ones are still in flight.
   always_comb begin
      busy_next     = (next_state != IDLE);
      done_next     = (next_state == DONE);
      start_accept  = (state == IDLE) && bus.start;
      sample_accept = (state == RUN) && bus.iq_valid && (accept_count < num_lat);
      last_shot     = v1 && ((shot_count_r + CNT_W'(1)) == num_lat);
   end

   // Batch configuration and acceptance counter
   always_ff @(posedge clk100) begin
      if (reset) begin
         num_lat      <= '0;
         wi_lat       <= '0;
         wq_lat       <= '0;
         th_lat       <= '0;
         accept_count <= '0;
      end else if (start_accept) begin
         num_lat      <= bus.num_shots;
         wi_lat       <= bus.w_i;
         wq_lat       <= bus.w_q;
         th_lat       <= bus.threshold;
         accept_count <= '0;
      end else if (sample_accept) begin
         accept_count <= accept_count + CNT_W'(1);
      end
   end

   // Stage 1: register the two weighted products of an accepted sample
   always_ff @(posedge clk100) begin
      if (reset) begin
         p_i <= '0;
         p_q <= '0;
         v1  <= 1'b0;
      end else begin
         v1 <= sample_accept;
         if (sample_accept) begin
            p_i <= i_ext * wi_ext;
            p_q <= q_ext * wq_ext;
         end
      end
   end

   // Stage 2: decide, and update the running totals in the same edge.
   // state_bit holds between results; the totals hold through IDLE until
   // the next accepted start clears them.
   always_ff @(posedge clk100) begin
      if (reset) begin
         state_valid_r   <= 1'b0;
         state_bit_r     <= 1'b0;
         shot_count_r    <= '0;
         excited_count_r <= '0;
      end else begin
         state_valid_r <= v1;
         if (start_accept) begin
            shot_count_r    <= '0;
            excited_count_r <= '0;
         end else if (v1) begin
            state_bit_r     <= excited;
            shot_count_r    <= shot_count_r + CNT_W'(1);
            excited_count_r <= excited_count_r + CNT_W'(excited);
         end
      end
   end

   assign bus.state_valid   = state_valid_r;
   assign bus.state_bit     = state_bit_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.shot_count    = shot_count_r;
   assign bus.excited_count = excited_count_r;

endmodule

// File: doc/iq_discriminator.md
IQ_DISCRIMINATOR -- requirements
Module: iq_discriminator

Interface
REQ-001 Parameter COEF_W, default 16: signed width of projection weights w_i, w_q.
REQ-002 Parameter CNT_W, default 16: width of num_shots, shot_count and excited_count.
REQ-003 clk100  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a shot batch.
REQ-006 num_shots  input  CNT_W  shots per batch, latched on accepted start.
REQ-007 w_i, w_q  input  COEF_W each  signed projection weights, latched on accepted start.
REQ-008 threshold  input  48  signed decision threshold, latched on accepted start.
REQ-009 iq_valid  input  1  one-cycle strobe from integrator marking a valid i_val/q_val.
REQ-010 i_val, q_val  input  32 each  signed integrated I/Q from integrator.
REQ-011 state_valid  output  1  one-cycle strobe marking a valid state_bit.
REQ-012 state_bit  output  1  shot classification, 1 = excited.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 done  output  1  one-cycle batch-complete pulse.
REQ-015 shot_count, excited_count  output  CNT_W each  classified shots and excited shots in current/last batch.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE; all outputs registered.
REQ-017 IDLE + start: latch num_shots, w_i, w_q, threshold; clear shot_count, excited_count, accept counter; go RUN, or go DONE if num_shots = 0.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 iq_valid SHALL be ignored in IDLE and DONE, and in RUN once accepted shots = num_shots.
REQ-020 Accepted sample, stage 1 (edge 1): register p_i = i_val*w_i, p_q = q_val*w_q, each signed 48 bit.
REQ-021 Stage 2 (edge 2): proj = p_i + p_q as signed 49 bit, threshold sign-extended to 49 bit; state_bit = 1 iff proj > threshold (equality gives 0).
REQ-022 state_valid SHALL be high for exactly the cycle after edge 2, i.e. latency 2 cycles from iq_valid, no gaps for back-to-back input.
REQ-023 Each state_valid: shot_count += 1, excited_count += state_bit, in the same edge as state_bit update.
REQ-024 RUN -> DONE on the edge where shot_count reaches num_shots; done high for exactly the one DONE cycle, then IDLE.
REQ-025 shot_count and excited_count SHALL hold their final values in IDLE until the next accepted start.
REQ-026 state_bit SHALL hold its last value when state_valid is low.
REQ-027 Accepted iq_valid strobes SHALL be one per cycle max; one pipeline slot per cycle, no back-pressure.

Reset
REQ-028 reset high at any edge: state IDLE; pipeline valids flushed; state_valid, state_bit, busy, done, shot_count, excited_count = 0.
REQ-029 Reset mid-RUN SHALL discard in-flight shots: no state_valid after the reset edge.
REQ-030 Reset SHALL take priority over start and iq_valid in the same cycle.

Verification
REQ-031 w_i=1, w_q=0, threshold=0, num_shots=4; i_val = 5, -3, 0, 7 (q_val=0) -> state_bit 1,0,0,1, each 2 cycles after iq_valid; done with shot_count=4, excited_count=2.
REQ-032 w_i=-2, w_q=3, i_val=10, q_val=7 (proj=1): threshold=0 -> state_bit=1; threshold=1 -> state_bit=0.
REQ-033 num_shots=0, start -> done high the cycle after start, counts 0, no state_valid, then IDLE.
REQ-034 num_shots=3, iq_valid on 5 consecutive cycles -> exactly 3 consecutive state_valid, shot_count=3, 4th/5th ignored.
REQ-035 Reset after 2 of 4 shots, with 1 in pipeline -> all outputs 0 next cycle; later iq_valid in IDLE -> no state_valid.
REQ-036 start pulsed mid-RUN with num_shots=9 -> ignored, batch completes at original num_shots.
